// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Bits needed to count 0..n-1 (ceil(log2(n))).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder, evaluated once per SHIFT cycle by serial_adder.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder with start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  serial_fa_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // Publish only the completed result; sum/cout never show partials.
          state_d = DONE;
          sum_d   = {fa_s, psum_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands.
  logic [W-1:0] exp_sum;
  logic         exp_cout, exp_ovf;
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    int sx, sy, ss;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    sx = int'($signed(x));
    sy = int'($signed(y));
    ss = sx + sy + int'(c);
    exp_ovf = (ss > 127) || (ss < -128);
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, ".cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // Called just after the accepting edge. Waits at negedges for done,
  // counting busy cycles; done must appear on the (W+1)th sample.
  // junk_start injects an ignored start mid-SHIFT.
  task automatic wait_done(input string tag, input bit junk_start, input logic [W-1:0] old_sum);
    int n, nbusy;
    n = 0; nbusy = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
      if (n == 3) chk({tag, ".hold"}, 32'(sum), 32'(old_sum));
      if (junk_start && n == 4) begin
        start = 1'b1; a = 8'hFF; b = $urandom; cin = 1'b1;
      end
      if (junk_start && n == 5) start = 1'b0;
    end
    chk({tag, ".lat"}, n, W + 1);
    chk({tag, ".busy"}, nbusy, W);
  endtask

  task automatic run_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input bit junk);
    logic [W-1:0] old;
    old = sum;
    @(posedge clk); #1;
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; cin = $urandom;
    model(x, y, c);
    wait_done(tag, junk, old);
    check_result(tag);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done), 0);
    check_result({tag, ".held"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.sum", 32'(sum), 0);
    chk("rst.cout", 32'(cout), 0);
    rst = 1'b0;

    run_add("t0f01", 8'h0F, 8'h01, 1'b0, 0);
    run_add("wrap", 8'hFF, 8'h01, 1'b0, 0);
    run_add("m80", 8'h80, 8'h80, 1'b1, 0);
    run_add("ign", 8'h55, 8'h33, 1'b0, 1);
    chk("ign.val", 32'(sum), 32'h88);

    // Abort mid-SHIFT.
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.sum", 32'(sum), 0);
    chk("abort.cout", 32'(cout), 0);
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort.nodone", seen, 0);
    end

    // Reset wins over start.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rstwin.busy", 32'(busy), 0);

    // Back-to-back: start held through the DONE cycle.
    @(posedge clk); #1;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model(8'h01, 8'h01, 1'b0);
    wait_done("b2b1", 0, 8'h00);
    check_result("b2b1");
    a = 8'h02; b = 8'h03; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n;
      n = 1;
      @(negedge clk);
      chk("b2b.busy", 32'(busy), 1);
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("b2b.period", n, W + 1);
      model(8'h02, 8'h03, 1'b0);
      check_result("b2b2");
    end

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = $urandom; y = $urandom;
      run_add("rnd", x, y, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
